alu_seq: RTL and testbench

//  Iterative ALU sequencer: drives the 16-bit alu (a, b, com -> y) from the

---
 rtl/alu_seq.sv | 160 ++++++++++++++++
 tb/tb_alu_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq - iterative ALU sequencer
//
// Drives an external combinational 16-bit alu (a, b, com -> y). One ALU
// command is repeated op_cnt times, and y is fed back into the accumulator
// that drives alu.a. This lets the control unit build multi-bit shifts,
// repeated add/sub and accumulate loops out of single-step ALU operations.
//
// Ports
//   clk      in   1   system clock, rising edge
//   rst_n    in   1   asynchronous active-low reset
//   start    in   1   request pulse, sampled only in IDLE
//   op_a     in   DW  initial accumulator value
//   op_b     in   DW  constant b operand, held for the whole run
//   op_com   in   3   ALU command
//   op_cnt   in   CW  number of iterations (0 = pass op_a straight through)
//   alu_a    out  DW  accumulator register, to alu.a
//   alu_b    out  DW  latched op_b, to alu.b
//   alu_com  out  3   latched op_com, to alu.com
//   alu_y    in   DW  alu result (combinational)
//   busy     out  1   high while iterations are running
//   done     out  1   one-cycle pulse; result is valid in this cycle
//   result   out  DW  final accumulator, held until the next run completes
//
// Configuration macro
//   ALU_SEQ_EARLY_EXIT_EN : when defined, a zero alu_y during RUN ends the
//   run immediately and skips the remaining iterations.
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int DW = 16,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] op_a,
  input  logic [DW-1:0] op_b,
  input  logic [2:0]    op_com,
  input  logic [CW-1:0] op_cnt,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_com,
  input  logic [DW-1:0] alu_y,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] DATA_ZERO = {DW{1'b0}};

  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_acc;
  logic [DW-1:0] w_acc_nxt;
  logic [DW-1:0] r_b;
  logic [DW-1:0] w_b_nxt;
  logic [2:0]    r_com;
  logic [2:0]    w_com_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_busy;
  logic          r_done;
  logic [DW-1:0] r_result;

  // Next-state and datapath update selection for the sequencer FSM
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_b_nxt     = r_b;
    w_com_nxt   = r_com;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_acc_nxt = op_a;
          w_b_nxt   = op_b;
          w_com_nxt = op_com;
          w_cnt_nxt = op_cnt;
          // A zero count skips RUN entirely so cnt can never wrap there.
          if (op_cnt != CNT_ZERO) begin
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        w_acc_nxt = alu_y;
        w_cnt_nxt = r_cnt - CNT_ONE;
`ifdef ALU_SEQ_EARLY_EXIT_EN
        if ((alu_y == DATA_ZERO) || (r_cnt == CNT_ONE)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
`else
        if (r_cnt == CNT_ONE) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
`endif
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, operand and output registers; status flags are derived from the
  // next state so busy/done/result line up with the cycle the FSM is in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_acc    <= DATA_ZERO;
      r_b      <= DATA_ZERO;
      r_com    <= 3'b000;
      r_cnt    <= CNT_ZERO;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= DATA_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_b     <= w_b_nxt;
      r_com   <= w_com_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt == S_RUN);
      r_done  <= (w_state_nxt == S_DONE);
      // Capture the final accumulator on entry to DONE so it is valid
      // together with the done pulse.
      if (w_state_nxt == S_DONE) begin
        r_result <= w_acc_nxt;
      end else begin
        r_result <= r_result;
      end
    end
  end

  assign alu_a   = r_acc;
  assign alu_b   = r_b;
  assign alu_com = r_com;
  assign busy    = r_busy;
  assign done    = r_done;
  assign result  = r_result;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  localparam int DW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [2:0]    op_com;
  logic [CW-1:0] op_cnt;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [2:0]    alu_com;
  logic [DW-1:0] alu_y;
  logic          busy;
  logic          done;
  logic [DW-1:0] result;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .op_a(op_a), .op_b(op_b), .op_com(op_com), .op_cnt(op_cnt),
    .alu_a(alu_a), .alu_b(alu_b), .alu_com(alu_com), .alu_y(alu_y),
    .busy(busy), .done(done), .result(result)
  );

  // Behaviour of the attached 16-bit alu.
  function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a,
                                          input logic [DW-1:0] b,
                                          input logic [2:0] com);
    case (com)
      3'd0:    return a;
      3'd1:    return b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a << 1;
      3'd5:    return a >> 1;
      3'd6:    return a + b;
      default: return a - b;
    endcase
  endfunction

  assign alu_y = alu_f(alu_a, alu_b, alu_com);

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: apply the op cnt times; latency is iterations + 1.
  task automatic model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [2:0] com, input logic [CW-1:0] cnt,
                       output logic [DW-1:0] res, output int lat);
    logic [DW-1:0] v;
    int iters;
    v = a;
    iters = 0;
    for (int i = 0; i < int'(cnt); i++) begin
      v = alu_f(v, b, com);
      iters++;
`ifdef ALU_SEQ_EARLY_EXIT_EN
      if (v == 16'h0000) break;
`endif
    end
    res = v;
    lat = iters + 1;
  endtask

  // One transaction. With hold_start, start stays high (with different
  // operands) through RUN and DONE and must be ignored.
  task automatic run(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                     input logic [2:0] com, input logic [CW-1:0] cnt, input bit hold_start);
    logic [DW-1:0] exp_res;
    int lat;
    bit seen;
    model(a, b, com, cnt, exp_res, lat);
    @(negedge clk);
    op_a = a; op_b = b; op_com = com; op_cnt = cnt; start = 1'b1;
    @(negedge clk);
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      if (k > 1) @(negedge clk);
      start = hold_start && (k <= lat);
      if (hold_start) begin
        op_a = 16'h1234; op_b = 16'h5555; op_com = 3'd6; op_cnt = 4'd1;
      end
      check_val({tag, "_busy"}, {31'd0, busy}, {31'd0, (k < lat)});
      check_val({tag, "_done"}, {31'd0, done}, {31'd0, (k == lat)});
      if (done) begin
        check_val({tag, "_result"}, {16'd0, result}, {16'd0, exp_res});
        seen = 1'b1;
      end
    end
    if (!seen) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    start = 1'b0;
    check_val({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check_val({tag, "_idle_done"}, {31'd0, done}, 32'd0);
    check_val({tag, "_held"}, {16'd0, result}, {16'd0, exp_res});
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0; start = 1'b0;
    op_a = 16'h0000; op_b = 16'h0000; op_com = 3'd0; op_cnt = 4'd0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_result", {16'd0, result}, 32'd0);
    check_val("rst_alu_a", {16'd0, alu_a}, 32'd0);
    rst_n = 1'b1;

    // Directed scenarios (shift, subtract, pass-through, long subtract).
    run("shl4", 16'h0001, 16'h0000, 3'd4, 4'd4, 1'b1);
    check_val("shl4_const", {16'd0, result}, 32'h0010);
    run("sub3", 16'h0005, 16'h0001, 3'd7, 4'd3, 1'b0);
    check_val("sub3_const", {16'd0, result}, 32'h0002);
    run("pass", 16'hBEEF, 16'h0000, 3'd0, 4'd0, 1'b0);
    check_val("pass_const", {16'd0, result}, 32'hBEEF);
    run("sub8", 16'h0003, 16'h0001, 3'd7, 4'd8, 1'b0);
`ifdef ALU_SEQ_EARLY_EXIT_EN
    check_val("sub8_const", {16'd0, result}, 32'h0000);
`else
    check_val("sub8_const", {16'd0, result}, 32'hFFFB);
`endif
    run("add15", 16'hFFF0, 16'h0003, 3'd6, 4'd15, 1'b0);

    // Reset in cycle 2 of a running shift aborts without a done pulse.
    @(negedge clk);
    op_a = 16'h0001; op_b = 16'h0000; op_com = 3'd4; op_cnt = 4'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("abort_busy", {31'd0, busy}, 32'd0);
    check_val("abort_done", {31'd0, done}, 32'd0);
    check_val("abort_result", {16'd0, result}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check_val("abort_no_done", pulses, 32'd0);

    // Randomized runs.
    for (int t = 0; t < 25; t++) begin
      run("rand", 16'($urandom), 16'($urandom), 3'($urandom_range(7, 0)),
          4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
